// File: rtl/board_vga_renderer.sv
// VGA renderer for the 4x4 tile game: 640x480@60 timing, once-per-frame state snapshot in
// vertical blank, and a 2-stage pixel pipeline producing 12-bit RGB with aligned syncs.
module board_vga_renderer #(
  parameter int CLK_DIV    = 4,
  parameter int BOARD_X0   = 128,
  parameter int BOARD_Y0   = 48,
  parameter int TILE_PITCH = 96,
  parameter int TILE_GAP   = 4,
  parameter int PREVIEW_Y0 = 16,
  parameter int PREVIEW_Y1 = 39,
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [79:0] board_flat,
  input  logic [1:0]  cursor_col,
  input  logic [4:0]  spawn_val,
  input  logic        game_over,
  input  logic        game_won,
  input  logic        display_ready,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic        snap_taken
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] GAP_LO   = 10'(TILE_GAP);
  localparam logic [9:0] GAP_HI   = 10'(TILE_PITCH - TILE_GAP - 1);
  localparam logic [9:0] PV_Y0    = 10'(PREVIEW_Y0);
  localparam logic [9:0] PV_Y1    = 10'(PREVIEW_Y1);

  typedef enum logic [1:0] {REG_BLANK, REG_BG, REG_BOARD, REG_PREVIEW} region_t;

  function automatic logic [9:0] x_edge(input int k);
    return 10'(BOARD_X0 + k * TILE_PITCH);
  endfunction

  function automatic logic [9:0] y_edge(input int k);
    return 10'(BOARD_Y0 + k * TILE_PITCH);
  endfunction

  function automatic logic [11:0] tile_colour(input logic [4:0] p);
    case (p)
      5'd0:    return 12'hCCB;
      5'd1:    return 12'hEED;
      5'd2:    return 12'hEDC;
      5'd3:    return 12'hFB7;
      5'd4:    return 12'hF96;
      5'd5:    return 12'hF75;
      5'd6:    return 12'hF53;
      5'd7:    return 12'hEC7;
      5'd8:    return 12'hEC6;
      5'd9:    return 12'hEC5;
      5'd10:   return 12'hEC3;
      5'd11:   return 12'hEC2;
      default: return 12'hFFF;
    endcase
  endfunction

  logic [DW-1:0] div;
  logic          tick;
  logic [9:0]    hc, vc;
  logic          snap_slot;

  assign tick      = (div == DIV_LAST);
  assign snap_slot = tick && (hc == 10'd0) && (vc == V_VIS);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (tick) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  logic [15:0][4:0] sh_tiles;
  logic [1:0]       sh_cursor;
  logic [4:0]       sh_spawn;
  logic             sh_over, sh_won;

  // NOTE: shadow registers are reset so the first frame draws a defined, empty board.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_tiles    <= '0;
      sh_cursor   <= '0;
      sh_spawn    <= '0;
      sh_over     <= 1'b0;
      sh_won      <= 1'b0;
      frame_start <= 1'b0;
      snap_taken  <= 1'b0;
    end else begin
      frame_start <= snap_slot;
      snap_taken  <= snap_slot && display_ready;
      if (snap_slot && display_ready) begin
        sh_tiles  <= board_flat;
        sh_cursor <= cursor_col;
        sh_spawn  <= spawn_val;
        sh_over   <= game_over;
        sh_won    <= game_won;
      end
    end
  end

  logic [1:0] col, row;
  logic [9:0] x_base, y_base, x_off, y_off;
  logic       in_x, in_y, inner_x, inner_y, visible, in_band;
  region_t    region_d;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    col    = 2'd0;
    x_base = x_edge(0);
    row    = 2'd0;
    y_base = y_edge(0);
    for (int k = 1; k < 4; k++) begin
      if (hc >= x_edge(k)) begin
        col    = 2'(k);
        x_base = x_edge(k);
      end
      if (vc >= y_edge(k)) begin
        row    = 2'(k);
        y_base = y_edge(k);
      end
    end
    x_off    = hc - x_base;
    y_off    = vc - y_base;
    in_x     = (hc >= x_edge(0)) && (hc < x_edge(4));
    in_y     = (vc >= y_edge(0)) && (vc < y_edge(4));
    inner_x  = (x_off >= GAP_LO) && (x_off <= GAP_HI);
    inner_y  = (y_off >= GAP_LO) && (y_off <= GAP_HI);
    visible  = (hc < H_VIS) && (vc < V_VIS);
    in_band  = (vc >= PV_Y0) && (vc <= PV_Y1);
    region_d = REG_BG;
    if (!visible)                                            region_d = REG_BLANK;
    else if (in_x && in_y)                                   region_d = REG_BOARD;
    else if (in_x && in_band && inner_x && col == sh_cursor) region_d = REG_PREVIEW;
  end

  region_t    s1_region;
  logic [3:0] s1_tile;
  logic       s1_inner, s1_hs, s1_vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_region <= REG_BLANK;
      s1_tile   <= '0;
      s1_inner  <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
    end else if (tick) begin
      s1_region <= region_d;
      s1_tile   <= {row, col};
      s1_inner  <= inner_x && inner_y;
      s1_hs     <= !((hc >= HS_FIRST) && (hc <= HS_LAST));
      s1_vs     <= !((vc >= VS_FIRST) && (vc <= VS_LAST));
    end
  end

  logic [11:0] status_colour;
  assign status_colour = sh_over ? 12'hF00 : (sh_won ? 12'h0F0 : 12'h555);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick) begin
      hsync <= s1_hs;
      vsync <= s1_vs;
      unique case (s1_region)
        REG_BOARD:   rgb <= s1_inner ? tile_colour(sh_tiles[s1_tile]) : status_colour;
        REG_PREVIEW: rgb <= tile_colour(sh_spawn);
        default:     rgb <= 12'h000;
      endcase
    end
  end

endmodule

// File: tb/tb_board_vga_renderer.sv
// Scoreboard bench for board_vga_renderer: a reduced-timing instance for multi-frame behaviour
// and a default-parameter instance for full 640x480 line timing.
module tb_board_vga_renderer;

  localparam int D        = 2;
  localparam int HV       = 64;
  localparam int HT       = 88;
  localparam int VV       = 48;
  localparam int VT       = 56;
  localparam int FRAME    = HT * VT;
  localparam int HS0      = 68;
  localparam int HS1      = 75;
  localparam int VS0      = 50;
  localparam int VS1      = 51;
  localparam int SNAP_POS = VV * HT;

  typedef struct {
    int          idx;
    logic [13:0] exp;
    string       name;
  } probe_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] board_flat;
  logic [1:0]  cursor_col;
  logic [4:0]  spawn_val;
  logic        game_over, game_won, display_ready;
  logic        hsync, vsync, frame_start, snap_taken;
  logic [11:0] rgb;
  logic        f_hsync, f_vsync, f_frame_start, f_snap_taken;
  logic [11:0] f_rgb;

  int     n_checks = 0;
  int     n_errors = 0;
  int     edges;
  probe_t pq[$];
  int     sq[$];

  always #5 clk = ~clk;

  // Shrunken blanking and board geometry keep several whole frames within a short run.
  board_vga_renderer #(
    .CLK_DIV(D), .BOARD_X0(16), .BOARD_Y0(12), .TILE_PITCH(8), .TILE_GAP(2),
    .PREVIEW_Y0(2), .PREVIEW_Y1(9),
    .H_VISIBLE(HV), .H_FRONT(4), .H_SYNC(8), .H_BACK(12),
    .V_VISIBLE(VV), .V_FRONT(2), .V_SYNC(2), .V_BACK(4)
  ) u_dut (
    .clk(clk), .rst(rst), .board_flat(board_flat), .cursor_col(cursor_col),
    .spawn_val(spawn_val), .game_over(game_over), .game_won(game_won),
    .display_ready(display_ready), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_start(frame_start), .snap_taken(snap_taken)
  );

  board_vga_renderer u_full (
    .clk(clk), .rst(rst), .board_flat(board_flat), .cursor_col(cursor_col),
    .spawn_val(spawn_val), .game_over(game_over), .game_won(game_won),
    .display_ready(display_ready), .hsync(f_hsync), .vsync(f_vsync), .rgb(f_rgb),
    .frame_start(f_frame_start), .snap_taken(f_snap_taken)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic hs_model(input int x);
    return !((x >= HS0) && (x <= HS1));
  endfunction

  function automatic logic vs_model(input int y);
    return !((y >= VS0) && (y <= VS1));
  endfunction

  task automatic probe(input int f, input int x, input int y, input logic [11:0] c);
    probe_t p;
    p.idx  = f * FRAME + y * HT + x;
    p.exp  = {c, hs_model(x), vs_model(y)};
    p.name = $sformatf("f%0d_px_%0d_%0d", f, x, y);
    pq.push_back(p);
  endtask

  task automatic wait_tick(input int t);
    while (edges < (t + 1) * D) @(negedge clk);
  endtask

  // Reduced-timing monitor: output pixel j is visible after the clk edge that ends tick j+1.
  initial begin : scaled_monitor
    int     j, x, y, pos;
    int     hs_lo, vs_lo, blank_bad;
    probe_t p;
    hs_lo = 0; vs_lo = 0; blank_bad = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_lo = 0; vs_lo = 0; blank_bad = 0;
      end else begin
        if (frame_start) begin
          pos = (edges % D == 0) ? ((edges / D - 1) % FRAME) : -1;
          check("frame_start_pos", 32'(pos), 32'(SNAP_POS));
          if (sq.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL frame_start_unexpected: got pulse at edge %0d, expected none", edges);
          end else begin
            check("snap_taken", 32'(snap_taken), 32'(sq.pop_front()));
          end
        end else if (snap_taken) begin
          n_checks++; n_errors++;
          $display("FAIL snap_without_frame_start: got snap_taken=1, expected 0");
        end
        if (edges % D == 0 && edges >= 2 * D) begin
          j = edges / D - 2;
          x = j % HT;
          y = (j / HT) % VT;
          while (pq.size() > 0 && pq[0].idx < j) begin
            p = pq.pop_front();
            n_checks++; n_errors++;
            $display("FAIL %s: got no sample, expected 0x%0h", p.name, p.exp);
          end
          if (pq.size() > 0 && pq[0].idx == j) begin
            p = pq.pop_front();
            check(p.name, 32'({rgb, hsync, vsync}), 32'(p.exp));
          end
          if (j / FRAME == 1) begin
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (!(x < HV && y < VV) && rgb != 12'h000) blank_bad++;
            if (j == 2 * FRAME - 1) begin
              check("hsync_low_per_frame", 32'(hs_lo), 32'((HS1 - HS0 + 1) * VT));
              check("vsync_low_per_frame", 32'(vs_lo), 32'((VS1 - VS0 + 1) * HT));
              check("blank_rgb_nonzero", 32'(blank_bad), 32'd0);
            end
          end
        end
      end
    end
  end

  // Default-parameter monitor over line 0 (CLK_DIV=4, 800-tick lines).
  initial begin : full_monitor
    int j, hs_lo;
    hs_lo = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hs_lo = 0;
      end else if (edges % 4 == 0 && edges >= 8) begin
        j = edges / 4 - 2;
        if (j < 800 && !f_hsync) hs_lo++;
        case (j)
          300: check("full_bg_px300",  32'({f_rgb, f_hsync, f_vsync}), 32'({12'h000, 1'b1, 1'b1}));
          655: check("full_px655",     32'({f_rgb, f_hsync, f_vsync}), 32'({12'h000, 1'b1, 1'b1}));
          656: check("full_px656",     32'({f_rgb, f_hsync, f_vsync}), 32'({12'h000, 1'b0, 1'b1}));
          751: check("full_px751",     32'({f_rgb, f_hsync, f_vsync}), 32'({12'h000, 1'b0, 1'b1}));
          752: check("full_px752",     32'({f_rgb, f_hsync, f_vsync}), 32'({12'h000, 1'b1, 1'b1}));
          799: check("full_hsync_low_line0", 32'(hs_lo), 32'd96);
          default: ;
        endcase
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_scaled"}, 32'({rgb, hsync, vsync, frame_start, snap_taken}),
          32'({12'h000, 1'b1, 1'b1, 1'b0, 1'b0}));
    check({tag, "_full"}, 32'({f_rgb, f_hsync, f_vsync, f_frame_start, f_snap_taken}),
          32'({12'h000, 1'b1, 1'b1, 1'b0, 1'b0}));
  endtask

  initial begin : stimulus
    int tiles[16] = '{3, 0, 1, 2, 4, 5, 6, 7, 8, 9, 10, 12, 13, 31, 11, 20};
    for (int i = 0; i < 16; i++) board_flat[i*5 +: 5] = 5'(tiles[i]);
    cursor_col    = 2'd2;
    spawn_val     = 5'd1;
    game_over     = 1'b0;
    game_won      = 1'b0;
    display_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset_poweron");
    rst = 1'b0;
    wait_tick(1500);

    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset("reset_midframe");
    repeat (3) @(negedge clk);

    // Frame 0 draws reset shadows; frame 1 draws snapshot 0.
    sq.push_back(1);
    probe(0, 18, 4, 12'hCCB); probe(0, 16, 12, 12'h555); probe(0, 18, 14, 12'hCCB);
    probe(1, 34, 1, 12'h000);
    probe(1, 18, 4, 12'h000); probe(1, 33, 4, 12'h000); probe(1, 34, 4, 12'hEED);
    probe(1, 37, 4, 12'hEED); probe(1, 38, 4, 12'h000);
    probe(1, 34, 9, 12'hEED); probe(1, 34, 10, 12'h000);
    probe(1, 19, 11, 12'h000); probe(1, 19, 12, 12'h555); probe(1, 19, 13, 12'h555);
    probe(1, 15, 14, 12'h000); probe(1, 19, 14, 12'hFB7); probe(1, 21, 14, 12'hFB7);
    probe(1, 22, 14, 12'h555); probe(1, 27, 14, 12'hCCB); probe(1, 35, 14, 12'hEED);
    probe(1, 43, 14, 12'hEDC); probe(1, 47, 14, 12'h555); probe(1, 48, 14, 12'h000);
    probe(1, 19, 22, 12'hF96); probe(1, 27, 22, 12'hF75); probe(1, 35, 22, 12'hF53);
    probe(1, 43, 22, 12'hEC7);
    probe(1, 19, 30, 12'hEC6); probe(1, 27, 30, 12'hEC5); probe(1, 35, 30, 12'hEC3);
    probe(1, 43, 30, 12'hFFF);
    probe(1, 19, 38, 12'hFFF); probe(1, 27, 38, 12'hFFF); probe(1, 33, 38, 12'h555);
    probe(1, 34, 38, 12'hEC2); probe(1, 35, 38, 12'hEC2); probe(1, 43, 38, 12'hFFF);
    probe(1, 19, 43, 12'h555); probe(1, 19, 44, 12'h000);
    probe(1, 67, 44, 12'h000); probe(1, 68, 44, 12'h000);
    probe(1, 75, 44, 12'h000); probe(1, 76, 44, 12'h000);
    probe(1, 0, 49, 12'h000); probe(1, 0, 50, 12'h000);
    probe(1, 87, 51, 12'h000); probe(1, 0, 52, 12'h000);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset_release_hold");

    // Mid-frame change with display_ready high must not leak into the frame being drawn.
    wait_tick(FRAME + 16 * HT);
    board_flat[4:0] = 5'd5;
    cursor_col      = 2'd0;
    game_over       = 1'b1;

    // Snapshot refused: frame 2 keeps the frame 1 picture.
    wait_tick(FRAME + 46 * HT);
    display_ready = 1'b0;
    sq.push_back(0);
    probe(2, 18, 4, 12'h000); probe(2, 34, 4, 12'hEED);
    probe(2, 19, 14, 12'hFB7); probe(2, 22, 14, 12'h555);

    // game_over and game_won both set: over has priority.
    wait_tick(2 * FRAME + 40 * HT);
    game_won      = 1'b1;
    display_ready = 1'b1;
    sq.push_back(1);
    probe(3, 18, 4, 12'hEED); probe(3, 34, 4, 12'h000);
    probe(3, 19, 14, 12'hF75); probe(3, 22, 14, 12'hF00); probe(3, 35, 38, 12'hEC2);

    wait_tick(3 * FRAME + 40 * HT);
    game_over = 1'b0;
    spawn_val = 5'd12;
    sq.push_back(1);
    probe(4, 18, 4, 12'hFFF); probe(4, 16, 12, 12'h0F0);
    probe(4, 19, 14, 12'hF75); probe(4, 22, 14, 12'h0F0);

    wait_tick(4 * FRAME + 46 * HT);
    check("probe_queue_drained", 32'(pq.size()), 32'd0);
    check("snap_queue_drained", 32'(sq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
